// File: rtl/idecode.sv
// Instruction decode stage for a LEGv8 pipeline. It holds the 32 x 64-bit register file and the ID/EX register.
// X31 always reads as zero. A write-back to a register that is read in the same cycle is forwarded to the output.
module idecode #(
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] cur_pc,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_index,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] sign_imm,
    output logic [DATA_W-1:0] pc_out,
    output logic [10:0]       opcode,
    output logic [4:0]        rd_index,
    output logic              reg2_loc,
    output logic              alu_src,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic              uncond_branch,
    output logic [1:0]        alu_op
);

    localparam logic [4:0]  ZERO_IDX = 5'(ZERO_REG);
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;

    logic [DATA_W-1:0] regs [32];

    logic [10:0]       op;
    logic [4:0]        rn_idx;
    logic [4:0]        r2_idx;
    logic              wb_en;

    logic              c_reg2_loc;
    logic              c_alu_src;
    logic              c_mem_to_reg;
    logic              c_reg_write;
    logic              c_mem_read;
    logic              c_mem_write;
    logic              c_branch;
    logic              c_uncond;
    logic [1:0]        c_alu_op;
    logic [DATA_W-1:0] c_imm;
    logic [DATA_W-1:0] c_rd1;
    logic [DATA_W-1:0] c_rd2;

    assign op     = instruction[31:21];
    assign rn_idx = instruction[9:5];
    assign r2_idx = c_reg2_loc ? instruction[4:0] : instruction[20:16];
    assign wb_en  = wb_reg_write && (wb_index != ZERO_IDX);

    always_comb begin
        c_reg2_loc   = 1'b0;
        c_alu_src    = 1'b0;
        c_mem_to_reg = 1'b0;
        c_reg_write  = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_write  = 1'b0;
        c_branch     = 1'b0;
        c_uncond     = 1'b0;
        c_alu_op     = 2'b00;
        c_imm        = '0;
        casez (op)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                c_reg_write = 1'b1;
                c_alu_op    = 2'b10;
            end
            OP_LDUR: begin
                c_alu_src    = 1'b1;
                c_mem_to_reg = 1'b1;
                c_reg_write  = 1'b1;
                c_mem_read   = 1'b1;
                c_imm        = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
            end
            OP_STUR: begin
                c_reg2_loc  = 1'b1;
                c_alu_src   = 1'b1;
                c_mem_write = 1'b1;
                c_imm       = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
            end
            11'b10110100???: begin
                c_reg2_loc = 1'b1;
                c_branch   = 1'b1;
                c_alu_op   = 2'b01;
                c_imm      = {{(DATA_W-19){instruction[23]}}, instruction[23:5]};
            end
            11'b000101?????: begin
                c_uncond = 1'b1;
                c_imm    = {{(DATA_W-26){instruction[25]}}, instruction[25:0]};
            end
            default: ;
        endcase
    end

    // Write-first read ports: a same-cycle write-back wins over the stored value.
    always_comb begin
        c_rd1 = '0;
        c_rd2 = '0;
        if (rn_idx != ZERO_IDX) begin
            c_rd1 = (wb_en && (wb_index == rn_idx)) ? wb_data : regs[rn_idx];
        end
        if (r2_idx != ZERO_IDX) begin
            c_rd2 = (wb_en && (wb_index == r2_idx)) ? wb_data : regs[r2_idx];
        end
    end

    // The register file keeps writing while stalled or flushed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_index] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || (flush && !stall)) begin
            read_data1    <= '0;
            read_data2    <= '0;
            sign_imm      <= '0;
            pc_out        <= '0;
            opcode        <= '0;
            rd_index      <= '0;
            reg2_loc      <= 1'b0;
            alu_src       <= 1'b0;
            mem_to_reg    <= 1'b0;
            reg_write     <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            branch        <= 1'b0;
            uncond_branch <= 1'b0;
            alu_op        <= 2'b00;
        end else if (!stall) begin
            read_data1    <= c_rd1;
            read_data2    <= c_rd2;
            sign_imm      <= c_imm;
            pc_out        <= cur_pc;
            opcode        <= op;
            rd_index      <= instruction[4:0];
            reg2_loc      <= c_reg2_loc;
            alu_src       <= c_alu_src;
            mem_to_reg    <= c_mem_to_reg;
            reg_write     <= c_reg_write;
            mem_read      <= c_mem_read;
            mem_write     <= c_mem_write;
            branch        <= c_branch;
            uncond_branch <= c_uncond;
            alu_op        <= c_alu_op;
        end
    end

endmodule

// File: tb/tb_idecode.sv
// Bench for idecode. It uses directed scenarios with hand-computed results, then random traffic.
// A behavioural model of the register file and decode is compared against the DUT every cycle.
module tb_idecode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [63:0] cur_pc;
    logic        stall, flush, wb_reg_write;
    logic [4:0]  wb_index;
    logic [63:0] wb_data;
    logic [63:0] read_data1, read_data2, sign_imm, pc_out;
    logic [10:0] opcode;
    logic [4:0]  rd_index;
    logic        reg2_loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, uncond_branch;
    logic [1:0]  alu_op;

    always #5 clk = ~clk;

    idecode #(.DATA_W(64), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .cur_pc(cur_pc),
        .stall(stall), .flush(flush), .wb_reg_write(wb_reg_write), .wb_index(wb_index),
        .wb_data(wb_data), .read_data1(read_data1), .read_data2(read_data2),
        .sign_imm(sign_imm), .pc_out(pc_out), .opcode(opcode), .rd_index(rd_index),
        .reg2_loc(reg2_loc), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .uncond_branch(uncond_branch), .alu_op(alu_op)
    );

    typedef struct packed {
        logic [63:0] rd1, rd2, imm, pc;
        logic [10:0] op;
        logic [4:0]  rd;
        logic        reg2_loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, uncond;
        logic [1:0]  alu_op;
    } out_t;

    out_t        dut_out, m_out;
    logic [63:0] m_regs [32];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          cmp_en   = 1'b0;

    assign dut_out = {read_data1, read_data2, sign_imm, pc_out, opcode, rd_index,
                      reg2_loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                      branch, uncond_branch, alu_op};

    task automatic check(input string name, input logic [281:0] got, input logic [281:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic out_t model_decode(input logic [31:0] ins, input logic [63:0] pc);
        out_t        o;
        logic [10:0] op;
        logic [63:0] w;
        int          rn, r2;
        op = ins[31:21];
        w  = {32'b0, ins};
        o  = '0;
        o.pc = pc;
        o.op = op;
        o.rd = ins[4:0];
        if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) begin
            o.reg_write = 1'b1;
            o.alu_op    = 2'd2;
        end else if (op == 11'h7C2) begin
            o.alu_src = 1'b1; o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.mem_read = 1'b1;
            o.imm = $signed(w << 43) >>> 55;
        end else if (op == 11'h7C0) begin
            o.reg2_loc = 1'b1; o.alu_src = 1'b1; o.mem_write = 1'b1;
            o.imm = $signed(w << 43) >>> 55;
        end else if (op[10:3] == 8'hB4) begin
            o.reg2_loc = 1'b1; o.branch = 1'b1; o.alu_op = 2'd1;
            o.imm = $signed(w << 40) >>> 45;
        end else if (op[10:5] == 6'b000101) begin
            o.uncond = 1'b1;
            o.imm = $signed(w << 38) >>> 38;
        end
        rn = int'(ins[9:5]);
        r2 = o.reg2_loc ? int'(ins[4:0]) : int'(ins[20:16]);
        o.rd1 = m_regs[rn];
        o.rd2 = m_regs[r2];
        return o;
    endfunction

    // Model: commit the write-back first, then read, so same-cycle forwarding falls out naturally.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_out = '0;
        end else begin
            if (wb_reg_write && wb_index != 5'd31) m_regs[wb_index] = wb_data;
            if (!stall) m_out = flush ? '0 : model_decode(instruction, cur_pc);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) check($sformatf("model_t%0t", $time), dut_out, m_out);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rnd_idx();
        int r;
        r = $urandom_range(0, 9);
        return (r >= 8) ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        logic [10:0] ops [6];
        ops[0] = 11'h458; ops[1] = 11'h658; ops[2] = 11'h450; ops[3] = 11'h550;
        ops[4] = 11'h7C2; ops[5] = 11'h7C0;
        k = $urandom_range(0, 8);
        if (k < 4) return {ops[k], rnd_idx(), 6'($urandom), rnd_idx(), rnd_idx()};
        if (k < 6) return {ops[k], 9'($urandom), 2'b00, rnd_idx(), rnd_idx()};
        if (k == 6) return {8'hB4, 19'($urandom), rnd_idx()};
        if (k == 7) return {6'b000101, 26'($urandom)};
        return $urandom;
    endfunction

    out_t exp_b, exp_add, e;

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        instruction = 32'h8B0500A1; cur_pc = 64'h44;
        wb_reg_write = 1'b1; wb_index = 5'd3; wb_data = 64'h5;
        step();
        cmp_en = 1'b1;
        step();
        check("reset_outputs", dut_out, '0);

        reset = 1'b1; wb_reg_write = 1'b0;
        for (int i = 0; i < 31; i++) begin
            instruction = {11'h458, 5'(i), 6'd0, 5'(i), 5'd0};
            step();
            check($sformatf("reset_reg_x%0d", i), {read_data1, read_data2}, '0);
        end

        wb_reg_write = 1'b1; wb_index = 5'd5; wb_data = 64'h1234; instruction = 32'h0;
        step();
        wb_reg_write = 1'b0; instruction = 32'h8B0500A1; cur_pc = 64'h100;
        step();
        e = '0; e.rd1 = 64'h1234; e.rd2 = 64'h1234; e.pc = 64'h100; e.op = 11'h458;
        e.rd = 5'd1; e.reg_write = 1'b1; e.alu_op = 2'b10;
        check("add_x5_x5", dut_out, e);

        wb_reg_write = 1'b1; wb_index = 5'd7; wb_data = 64'd99;
        instruction = 32'hF85F80E2; cur_pc = 64'h104;
        step();
        e = '0; e.rd1 = 64'd99; e.imm = 64'hFFFF_FFFF_FFFF_FFF8; e.pc = 64'h104;
        e.op = 11'h7C2; e.rd = 5'd2; e.alu_src = 1'b1; e.mem_to_reg = 1'b1;
        e.reg_write = 1'b1; e.mem_read = 1'b1;
        check("ldur_bypass", dut_out, e);

        wb_index = 5'd31; wb_data = 64'hDEAD; instruction = 32'h0;
        step();
        instruction = 32'hB4FFFFFF; cur_pc = 64'h108;
        step();
        e = '0; e.imm = '1; e.pc = 64'h108; e.op = 11'h5A7; e.rd = 5'd31;
        e.reg2_loc = 1'b1; e.branch = 1'b1; e.alu_op = 2'b01;
        check("cbz_xzr", dut_out, e);

        wb_reg_write = 1'b0; instruction = 32'h16000000; cur_pc = 64'h400;
        step();
        exp_b = '0; exp_b.imm = 64'hFFFF_FFFF_FE00_0000; exp_b.pc = 64'h400;
        exp_b.op = 11'h0B0; exp_b.uncond = 1'b1;
        check("b_neg_imm", dut_out, exp_b);

        stall = 1'b1; wb_reg_write = 1'b1; wb_index = 5'd9; wb_data = 64'd77;
        for (int i = 0; i < 3; i++) begin
            instruction = rand_instr(); cur_pc = {$urandom, $urandom};
            step();
            check($sformatf("stall_hold_%0d", i), dut_out, exp_b);
        end
        stall = 1'b0; flush = 1'b1; wb_reg_write = 1'b0;
        instruction = {11'h458, 5'd9, 6'd0, 5'd9, 5'd1}; cur_pc = 64'h500;
        step();
        check("flush_bubble", dut_out, '0);
        flush = 1'b0;
        step();
        exp_add = '0; exp_add.rd1 = 64'd77; exp_add.rd2 = 64'd77; exp_add.pc = 64'h500;
        exp_add.op = 11'h458; exp_add.rd = 5'd1; exp_add.reg_write = 1'b1; exp_add.alu_op = 2'b10;
        check("write_during_stall", dut_out, exp_add);
        stall = 1'b1; flush = 1'b1; instruction = 32'hF85F80E2; cur_pc = 64'h600;
        step();
        step();
        check("stall_beats_flush", dut_out, exp_add);
        stall = 1'b0; flush = 1'b0; instruction = 32'h16000000; cur_pc = 64'h400;
        step();
        check("flush_not_remembered", dut_out, exp_b);

        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 63) != 0);
            stall        = ($urandom_range(0, 7) == 0);
            flush        = ($urandom_range(0, 7) == 0);
            wb_reg_write = $urandom_range(0, 1) == 1;
            wb_index     = rnd_idx();
            wb_data      = {$urandom, $urandom};
            instruction  = rand_instr();
            cur_pc       = {$urandom, $urandom};
            step();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
